// File: rtl/mem_arbiter_if.sv
// Memory-port bundle between the arbiter (master) and the DDR controller mem (slave).
// Handshake: memreq rises with memaddr/memwr/memwdata and all four hold until memack is sampled high; memack is a one-cycle pulse with memrdata valid in that cycle.
interface mem_arbiter_if #(
    parameter int AW = 20,
    parameter int DW = 32
);
    logic          memreq;
    logic [AW-1:0] memaddr;
    logic          memwr;
    logic [DW-1:0] memwdata;
    logic          memack;
    logic [DW-1:0] memrdata;

    modport master (output memreq, memaddr, memwr, memwdata, input memack, memrdata);
    modport slave  (input memreq, memaddr, memwr, memwdata, output memack, memrdata);
endinterface

// File: rtl/mem_arbiter.sv
// N-channel req/ack arbiter onto the single DDR port: round-robin or fixed priority with
// starvation promotion, plus per-channel grant locking for back-to-back accesses.
module mem_arbiter #(
    parameter int NCH     = 4,
    parameter int AW      = 20,
    parameter int DW      = 32,
    parameter int PRIO    = 0,
    parameter int MAXWAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    chreq,
    input  logic [NCH*AW-1:0] chaddr,
    input  logic [NCH-1:0]    chwr,
    input  logic [NCH*DW-1:0] chwdata,
    input  logic [NCH-1:0]    chlock,
    output logic [NCH-1:0]    chack,
    output logic [DW-1:0]     chrdata,
    mem_arbiter_if.master     mem,
    output logic [NCH-1:0]    grant,
    output logic [1:0]        state_dbg
);
    localparam int IW = $clog2(NCH);
    localparam logic [7:0] MAXW = 8'(MAXWAIT);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, owner, win, ptr_nx;
    logic [IW:0]   rr_sum;
    logic [7:0]    wait_cnt [NCH];
    logic          lock_q, lock_hit, any_req, sel_found;
    logic          do_select, do_ack, do_done, idle_clear;

    assign any_req   = |chreq;
    assign lock_hit  = lock_q && chreq[owner];
    assign ptr_nx    = (win == IW'(NCH - 1)) ? '0 : win + 1'b1;
    assign state_dbg = state;

    // Winner selection; only consumed in IDLE when some channel is requesting.
    always_comb begin
        win       = owner;
        sel_found = lock_hit;
        rr_sum    = '0;
        if (!lock_hit) begin
            if (PRIO != 0) begin
                for (int i = 0; i < NCH; i++) begin
                    if (!sel_found && chreq[i] && wait_cnt[i] >= MAXW) begin
                        win       = IW'(i);
                        sel_found = 1'b1;
                    end
                end
                for (int i = 0; i < NCH; i++) begin
                    if (!sel_found && chreq[i]) begin
                        win       = IW'(i);
                        sel_found = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    rr_sum = {1'b0, ptr} + (IW+1)'(k);
                    if (rr_sum >= (IW+1)'(NCH)) rr_sum = rr_sum - (IW+1)'(NCH);
                    if (!sel_found && chreq[rr_sum[IW-1:0]]) begin
                        win       = rr_sum[IW-1:0];
                        sel_found = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   if (mem.memack) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_select  = 1'b0;
        do_ack     = 1'b0;
        do_done    = 1'b0;
        idle_clear = 1'b0;
        case (state)
            IDLE: begin
                do_select  = any_req;
                idle_clear = !any_req;
            end
            ISSUE:   do_ack  = mem.memack;
            DONE:    do_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chack        <= '0;
            chrdata      <= '0;
            mem.memreq   <= 1'b0;
            mem.memaddr  <= '0;
            mem.memwr    <= 1'b0;
            mem.memwdata <= '0;
            grant        <= '0;
            owner        <= '0;
            ptr          <= '0;
            lock_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) wait_cnt[i] <= '0;
        end else begin
            if (do_select) begin
                mem.memreq   <= 1'b1;
                mem.memaddr  <= chaddr[win*AW +: AW];
                mem.memwr    <= chwr[win];
                mem.memwdata <= chwdata[win*DW +: DW];
                grant        <= NCH'(1) << win;
                owner        <= win;
                lock_q       <= 1'b0;
                // A locked re-grant leaves the rotation where the lock found it.
                if (!lock_hit) ptr <= ptr_nx;
            end else if (idle_clear) begin
                grant  <= '0;
                lock_q <= 1'b0;
            end
            if (do_ack) begin
                mem.memreq <= 1'b0;
                chack      <= grant;
                chrdata    <= mem.memrdata;
                lock_q     <= chlock[owner];
            end
            if (do_done) begin
                chack <= '0;
                if (!lock_q) grant <= '0;
            end
            if (state == IDLE) begin
                for (int i = 0; i < NCH; i++) begin
                    if (!chreq[i] || win == IW'(i)) wait_cnt[i] <= '0;
                    else if (wait_cnt[i] != 8'hFF) wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance driven side by side,
// each checked every cycle against a transaction-rule model plus expected grant orders.
module tb_mem_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int MW  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0]    chreq [2], chwr [2], chlock [2], chack [2], grant [2];
  logic [NCH*AW-1:0] chaddr [2];
  logic [NCH*DW-1:0] chwdata [2];
  logic [DW-1:0]     chrdata [2], mrdata [2], mwdata [2];
  logic [1:0]        state_dbg [2];
  logic              mack [2], mreq [2], mwr [2];
  logic [AW-1:0]     maddr [2];

  mem_arbiter_if #(.AW(AW), .DW(DW)) mif0 ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) mif1 ();

  assign mif0.memack   = mack[0];
  assign mif0.memrdata = mrdata[0];
  assign mif1.memack   = mack[1];
  assign mif1.memrdata = mrdata[1];
  assign mreq[0]   = mif0.memreq;
  assign maddr[0]  = mif0.memaddr;
  assign mwr[0]    = mif0.memwr;
  assign mwdata[0] = mif0.memwdata;
  assign mreq[1]   = mif1.memreq;
  assign maddr[1]  = mif1.memaddr;
  assign mwr[1]    = mif1.memwr;
  assign mwdata[1] = mif1.memwdata;

  mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO(0), .MAXWAIT(MW)) dut_rr (
    .clk(clk), .rst(rst), .chreq(chreq[0]), .chaddr(chaddr[0]), .chwr(chwr[0]),
    .chwdata(chwdata[0]), .chlock(chlock[0]), .chack(chack[0]), .chrdata(chrdata[0]),
    .mem(mif0), .grant(grant[0]), .state_dbg(state_dbg[0]));

  mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO(1), .MAXWAIT(MW)) dut_fp (
    .clk(clk), .rst(rst), .chreq(chreq[1]), .chaddr(chaddr[1]), .chwr(chwr[1]),
    .chwdata(chwdata[1]), .chlock(chlock[1]), .chack(chack[1]), .chrdata(chrdata[1]),
    .mem(mif1), .grant(grant[1]), .state_dbg(state_dbg[1]));

  int n_checks = 0;
  int n_pass   = 0;

  // client and memory stimulus state
  int   pend [2][NCH];
  logic lockm [2][NCH];
  bit   rnd_on, mem_on;
  bit   sb_on [2];
  bit   spur [2], acked [2];
  int   lat_cfg;
  int   lat_cnt [2], lat_cur [2];
  logic [3:0] exp_q0 [$];
  logic [3:0] exp_q1 [$];

  // reference model: phase 0 waiting, 1 access outstanding, 2 completion cycle
  int             m_st [2], m_owner [2], m_lockch [2], m_ptr [2];
  int             m_wait [2][NCH];
  logic [NCH-1:0] m_grant [2], m_chack [2];
  logic           m_memreq [2], m_wr [2];
  logic [AW-1:0]  m_addr [2];
  logic [DW-1:0]  m_wd [2], m_rd [2];

  typedef struct {
    logic [15:0] cnt;
    logic [3:0]  lock;
    logic [3:0]  late;
    int          lat;
    int          n;
    logic [31:0] ord_rr;
    logic [31:0] ord_fp;
  } vec_t;
  vec_t tv [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic new_payload(input int j, input int i);
    chaddr[j][i*AW +: AW]  = AW'($urandom);
    chwdata[j][i*DW +: DW] = $urandom;
    chwr[j][i]             = 1'($urandom_range(0, 1));
  endtask

  task automatic post(input int j, input int i, input int n, input logic lk);
    pend[j][i]   = n;
    lockm[j][i]  = lk;
    new_payload(j, i);
    chreq[j][i]  = 1'b1;
    chlock[j][i] = lk;
  endtask

  task automatic set_lat(input int x);
    lat_cfg = x;
    for (int j = 0; j < 2; j++) lat_cur[j] = (x < 0) ? $urandom_range(0, 3) : x;
  endtask

  task automatic model_step(input int j);
    logic [NCH-1:0] rq;
    int w;
    bit lk_win;
    rq = chreq[j];
    if (rst) begin
      m_st[j] = 0; m_owner[j] = 0; m_lockch[j] = -1; m_ptr[j] = 0;
      m_grant[j] = '0; m_chack[j] = '0; m_memreq[j] = 1'b0; m_wr[j] = 1'b0;
      m_addr[j] = '0; m_wd[j] = '0; m_rd[j] = '0;
      for (int i = 0; i < NCH; i++) m_wait[j][i] = 0;
      return;
    end
    case (m_st[j])
      0: begin
        if (rq != '0) begin
          w = -1;
          lk_win = 1'b0;
          if (m_lockch[j] >= 0 && rq[m_lockch[j]]) begin
            w = m_lockch[j];
            lk_win = 1'b1;
          end else if (j == 1) begin
            for (int i = 0; i < NCH; i++) if (w < 0 && rq[i] && m_wait[j][i] >= MW) w = i;
            for (int i = 0; i < NCH; i++) if (w < 0 && rq[i]) w = i;
          end else begin
            for (int k = 0; k < NCH; k++) if (w < 0 && rq[(m_ptr[j] + k) % NCH]) w = (m_ptr[j] + k) % NCH;
          end
          for (int i = 0; i < NCH; i++)
            m_wait[j][i] = (!rq[i] || i == w) ? 0 : ((m_wait[j][i] < 255) ? m_wait[j][i] + 1 : 255);
          if (!lk_win) m_ptr[j] = (w + 1) % NCH;
          m_lockch[j] = -1;
          m_grant[j]  = NCH'(1) << w;
          m_owner[j]  = w;
          m_memreq[j] = 1'b1;
          m_addr[j]   = chaddr[j][w*AW +: AW];
          m_wr[j]     = chwr[j][w];
          m_wd[j]     = chwdata[j][w*DW +: DW];
          m_st[j]     = 1;
        end else begin
          for (int i = 0; i < NCH; i++) m_wait[j][i] = 0;
          m_lockch[j] = -1;
          m_grant[j]  = '0;
        end
      end
      1: begin
        if (mack[j]) begin
          m_memreq[j] = 1'b0;
          m_chack[j]  = NCH'(1) << m_owner[j];
          m_rd[j]     = mrdata[j];
          m_lockch[j] = chlock[j][m_owner[j]] ? m_owner[j] : -1;
          m_st[j]     = 2;
        end
      end
      default: begin
        m_chack[j] = '0;
        if (m_lockch[j] < 0) m_grant[j] = '0;
        m_st[j] = 0;
      end
    endcase
  endtask

  task automatic record(input int j);
    int idx;
    logic [3:0] e;
    if (!sb_on[j] || chack[j] == '0) return;
    idx = 15;
    for (int i = 0; i < NCH; i++) if (chack[j] == (NCH'(1) << i)) idx = i;
    if ((j == 0 && exp_q0.size() == 0) || (j == 1 && exp_q1.size() == 0)) begin
      n_checks++;
      $display("FAIL order_dut%0d: got ch%0d expected no further grant", j, idx);
      return;
    end
    e = (j == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check($sformatf("order_dut%0d", j), 64'(idx), 64'(e));
  endtask

  task automatic clients(input int j);
    for (int i = 0; i < NCH; i++) begin
      if (chack[j][i] && pend[j][i] > 0) begin
        pend[j][i]--;
        if (pend[j][i] > 0) new_payload(j, i);
      end
      if (rnd_on && pend[j][i] == 0 && $urandom_range(0, 7) == 0) begin
        pend[j][i]  = $urandom_range(1, 3);
        lockm[j][i] = 1'($urandom_range(0, 1));
        new_payload(j, i);
      end
      chreq[j][i]  = (pend[j][i] > 0);
      chlock[j][i] = (pend[j][i] > 0) && lockm[j][i];
    end
  endtask

  task automatic mem_resp(input int j);
    mack[j] = 1'b0;
    if (spur[j]) begin
      mack[j]   = 1'b1;
      mrdata[j] = $urandom;
      spur[j]   = 1'b0;
    end else if (mem_on && mreq[j] && !acked[j]) begin
      if (lat_cnt[j] >= lat_cur[j]) begin
        mack[j]    = 1'b1;
        mrdata[j]  = (lat_cur[j] == 5) ? 32'hDEADBEEF : $urandom;
        acked[j]   = 1'b1;
        lat_cnt[j] = 0;
        lat_cur[j] = (lat_cfg < 0) ? $urandom_range(0, 3) : lat_cfg;
      end else lat_cnt[j]++;
    end
    if (!mreq[j]) begin
      acked[j]   = 1'b0;
      lat_cnt[j] = 0;
    end
  endtask

  // per-cycle process: model the edge just taken, compare, then react for the next edge
  always begin
    @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      model_step(j);
      check($sformatf("memreq_dut%0d", j),  64'(mreq[j]),    64'(m_memreq[j]));
      check($sformatf("grant_dut%0d", j),   64'(grant[j]),   64'(m_grant[j]));
      check($sformatf("chack_dut%0d", j),   64'(chack[j]),   64'(m_chack[j]));
      check($sformatf("memaddr_dut%0d", j), 64'(maddr[j]),   64'(m_addr[j]));
      check($sformatf("memwr_dut%0d", j),   64'(mwr[j]),     64'(m_wr[j]));
      check($sformatf("memwdata_dut%0d", j),64'(mwdata[j]),  64'(m_wd[j]));
      check($sformatf("chrdata_dut%0d", j), 64'(chrdata[j]), 64'(m_rd[j]));
      record(j);
      clients(j);
      mem_resp(j);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      tick(1);
      if (chreq[0] == '0 && chreq[1] == '0 && m_st[0] == 0 && m_st[1] == 0 && !mreq[0] && !mreq[1]) begin
        tick(2);
        return;
      end
    end
    n_checks++;
    $display("FAIL drain_timeout: got still busy after %0d cycles expected idle", max_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rnd_on = 1'b0;
    mem_on = 1'b1;
    for (int j = 0; j < 2; j++) begin
      chreq[j] = '0; chwr[j] = '0; chlock[j] = '0; chaddr[j] = '0; chwdata[j] = '0;
      mack[j] = 1'b0; mrdata[j] = '0; spur[j] = 1'b0; acked[j] = 1'b0; lat_cnt[j] = 0;
      sb_on[j] = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        pend[j][i]  = 0;
        lockm[j][i] = 1'b0;
      end
    end
    set_lat(0);
    // cnt nibble i = accesses by channel i; order nibble k = k-th granted channel
    tv[0] = '{16'h0100, 4'h0, 4'h0, 5, 1, 32'h0000_0002, 32'h0000_0002};
    tv[1] = '{16'h1111, 4'h0, 4'h0, 0, 4, 32'h0000_2103, 32'h0000_3210};
    tv[2] = '{16'h0021, 4'h2, 4'h1, 0, 3, 32'h0000_0011, 32'h0000_0011};
    tv[3] = '{16'h0021, 4'h0, 4'h1, 0, 3, 32'h0000_0101, 32'h0000_0101};
    tv[4] = '{16'h2006, 4'h0, 4'h0, 0, 8, 32'h0000_0303, 32'h3000_3000};

    tick(4);
    rst = 1'b0;
    tick(2);

    for (int v = 0; v < 5; v++) begin
      logic [31:0] orr, ofp;
      logic [15:0] cn;
      orr = tv[v].ord_rr;
      ofp = tv[v].ord_fp;
      cn  = tv[v].cnt;
      set_lat(tv[v].lat);
      for (int k = 0; k < tv[v].n; k++) begin
        exp_q0.push_back(orr[k*4 +: 4]);
        exp_q1.push_back(ofp[k*4 +: 4]);
      end
      sb_on[0] = 1'b1;
      sb_on[1] = 1'b1;
      for (int j = 0; j < 2; j++)
        for (int i = 0; i < NCH; i++)
          if (cn[i*4 +: 4] != 0 && !tv[v].late[i]) post(j, i, int'(cn[i*4 +: 4]), tv[v].lock[i]);
      for (int j = 0; j < 2; j++) begin
        if (v == 0) begin
          chaddr[j][2*AW +: AW] = 20'h12345;
          chwr[j][2] = 1'b0;
        end
        if (v == 2) begin
          chwdata[j][1*DW +: DW] = 32'hA5A5A5A5;
          chwr[j][1] = 1'b1;
        end
      end
      tick(1);
      for (int j = 0; j < 2; j++)
        for (int i = 0; i < NCH; i++)
          if (cn[i*4 +: 4] != 0 && tv[v].late[i]) post(j, i, int'(cn[i*4 +: 4]), tv[v].lock[i]);
      wait_drain(400);
      sb_on[0] = 1'b0;
      sb_on[1] = 1'b0;
      check($sformatf("order_left_dut0_v%0d", v), 64'(exp_q0.size()), 64'd0);
      check($sformatf("order_left_dut1_v%0d", v), 64'(exp_q1.size()), 64'd0);
      exp_q0.delete();
      exp_q1.delete();
    end

    // round robin under saturation: rotation resumes at channel 1
    set_lat(0);
    for (int k = 0; k < 100; k++) exp_q0.push_back(4'((1 + k) % NCH));
    sb_on[0] = 1'b1;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NCH; i++) post(j, i, 25, 1'b0);
    wait_drain(1500);
    sb_on[0] = 1'b0;
    check("rr100_left", 64'(exp_q0.size()), 64'd0);
    exp_q0.delete();

    // reset while an access is outstanding, then a stray ack just after reset
    mem_on = 1'b0;
    for (int j = 0; j < 2; j++) post(j, 2, 1, 1'b0);
    tick(4);
    rst = 1'b1;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NCH; i++) pend[j][i] = 0;
    for (int j = 0; j < 2; j++) chreq[j] = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    spur[0] = 1'b1;
    spur[1] = 1'b1;
    tick(3);
    mem_on = 1'b1;

    // stray ack while idle with nobody requesting
    spur[0] = 1'b1;
    spur[1] = 1'b1;
    tick(4);

    // randomized traffic with variable memory latency
    set_lat(-1);
    rnd_on = 1'b1;
    tick(1500);
    rnd_on = 1'b0;
    wait_drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
